// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge RAM bridge.
package cart_pkg;

    localparam int CART_ADDR_W = 25;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2
    } bridge_state_t;

endpackage

// File: rtl/cart_ram_bridge.sv
// Bridges the mapper's byte RAM interface to the shared SDRAM port, with a
// one-entry posted-write buffer and a one-entry read cache.
//
// state   | meaning
// IDLE    | no SDRAM request outstanding
// WR_BUSY | buffered write issued, waiting for ack
// RD_BUSY | cache-miss read issued, waiting for ack
module cart_ram_bridge
    import cart_pkg::*;
#(
    parameter int         ADDR_W    = CART_ADDR_W,
    parameter logic [7:0] IDLE_DOUT = 8'hFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_din,
    input  logic              ram_we,
    input  logic              ram_rd,
    input  logic              flush,
    output logic [7:0]        ram_dout,
    output logic              ram_ready,
    output logic              cpu_wait,
    output logic              overflow,
    output logic              sdram_req,
    output logic              sdram_we,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [7:0]        sdram_din,
    input  logic              sdram_ack,
    input  logic [7:0]        sdram_dout
);

    bridge_state_t     state, state_nxt;
    logic              wbuf_valid, wbuf_valid_nxt;
    logic [ADDR_W-1:0] wbuf_addr, wbuf_addr_nxt;
    logic [7:0]        wbuf_data, wbuf_data_nxt;
    logic              cache_valid, cache_valid_nxt;
    logic [ADDR_W-1:0] cache_tag, cache_tag_nxt;
    logic [ADDR_W-1:0] rd_tag, rd_tag_nxt;
    logic [7:0]        dout_nxt;
    logic              flush_seen, flush_seen_nxt;
    logic              overflow_nxt;
    logic              req_nxt, we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        din_nxt;
    logic              hit;

    assign hit      = cache_valid && (cache_tag == ram_addr);
    assign cpu_wait = ram_rd && !hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wbuf_valid  <= 1'b0;
            wbuf_addr   <= '0;
            wbuf_data   <= 8'h00;
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            rd_tag      <= '0;
            ram_dout    <= IDLE_DOUT;
            flush_seen  <= 1'b0;
            overflow    <= 1'b0;
            ram_ready   <= 1'b1;
            sdram_req   <= 1'b0;
            sdram_we    <= 1'b0;
            sdram_addr  <= '0;
            sdram_din   <= 8'h00;
        end else begin
            state       <= state_nxt;
            wbuf_valid  <= wbuf_valid_nxt;
            wbuf_addr   <= wbuf_addr_nxt;
            wbuf_data   <= wbuf_data_nxt;
            cache_valid <= cache_valid_nxt;
            cache_tag   <= cache_tag_nxt;
            rd_tag      <= rd_tag_nxt;
            ram_dout    <= dout_nxt;
            flush_seen  <= flush_seen_nxt;
            overflow    <= overflow_nxt;
            ram_ready   <= !wbuf_valid_nxt;
            sdram_req   <= req_nxt;
            sdram_we    <= we_nxt;
            sdram_addr  <= addr_nxt;
            sdram_din   <= din_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wbuf_valid_nxt  = wbuf_valid;
        wbuf_addr_nxt   = wbuf_addr;
        wbuf_data_nxt   = wbuf_data;
        cache_valid_nxt = cache_valid;
        cache_tag_nxt   = cache_tag;
        rd_tag_nxt      = rd_tag;
        dout_nxt        = ram_dout;
        flush_seen_nxt  = flush_seen;
        overflow_nxt    = overflow;
        req_nxt         = sdram_req;
        we_nxt          = sdram_we;
        addr_nxt        = sdram_addr;
        din_nxt         = sdram_din;

        // The buffer only fills when empty and only drains in WR_BUSY, so the
        // two updates below never touch wbuf_valid in the same cycle.
        if (ram_we) begin
            if (!wbuf_valid) begin
                wbuf_valid_nxt = 1'b1;
                wbuf_addr_nxt  = ram_addr;
                wbuf_data_nxt  = ram_din;
            end else begin
                overflow_nxt = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (wbuf_valid) begin
                    req_nxt   = 1'b1;
                    we_nxt    = 1'b1;
                    addr_nxt  = wbuf_addr;
                    din_nxt   = wbuf_data;
                    state_nxt = WR_BUSY;
                end else if (ram_rd && !hit) begin
                    req_nxt        = 1'b1;
                    we_nxt         = 1'b0;
                    addr_nxt       = ram_addr;
                    rd_tag_nxt     = ram_addr;
                    flush_seen_nxt = 1'b0;
                    state_nxt      = RD_BUSY;
                end
            end
            WR_BUSY: begin
                if (sdram_ack) begin
                    req_nxt        = 1'b0;
                    wbuf_valid_nxt = 1'b0;
                    if (cache_valid && (cache_tag == wbuf_addr)) begin
                        dout_nxt = wbuf_data;
                    end
                    state_nxt = IDLE;
                end
            end
            RD_BUSY: begin
                if (flush) begin
                    flush_seen_nxt = 1'b1;
                end
                if (sdram_ack) begin
                    req_nxt         = 1'b0;
                    cache_tag_nxt   = rd_tag;
                    dout_nxt        = sdram_dout;
                    cache_valid_nxt = !(flush_seen || flush);
                    state_nxt       = IDLE;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        // A flush overrides any fill or write-through landing this cycle.
        if (flush) begin
            cache_valid_nxt = 1'b0;
            dout_nxt        = IDLE_DOUT;
        end
    end

endmodule

// File: tb/tb_cart_ram_bridge.sv
// Self-checking bench for cart_ram_bridge: table of transactions plus
// hand-timed corner sequences, with an SDRAM request scoreboard.
module tb_cart_ram_bridge;

    localparam logic [7:0] IDLE_V = 8'hFF;
    localparam logic [1:0] OP_RD = 2'd0, OP_WR = 2'd1, OP_FL = 2'd2;

    typedef struct {
        logic        we;
        logic [24:0] addr;
        logic [7:0]  din;
    } sb_t;

    typedef struct {
        logic [1:0]  op;
        logic [24:0] addr;
        logic [7:0]  data;
        logic        exp_miss;
        logic [7:0]  exp_dout;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [24:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we, ram_rd, flush;
    logic [7:0]  ram_dout;
    logic        ram_ready, cpu_wait, overflow;
    logic        sdram_req, sdram_we;
    logic [24:0] sdram_addr;
    logic [7:0]  sdram_din;
    logic        sdram_ack;
    logic [7:0]  sdram_dout;

    logic        ack_auto, ack_man, auto_ack, prev_req;
    logic [7:0]  dout_auto, dout_man;
    int          ack_delay, req_age;
    int          checks = 0;
    int          errors = 0;
    sb_t         sb[$];
    logic [7:0]  mem [logic [24:0]];
    vec_t        vecs [11];

    assign sdram_ack  = ack_auto | ack_man;
    assign sdram_dout = ack_man ? dout_man : dout_auto;

    always #5 clk = ~clk;

    cart_ram_bridge #(.ADDR_W(25), .IDLE_DOUT(8'hFF)) dut (
        .clk(clk), .reset_n(reset_n),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_rd(ram_rd),
        .flush(flush), .ram_dout(ram_dout), .ram_ready(ram_ready),
        .cpu_wait(cpu_wait), .overflow(overflow),
        .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_addr(sdram_addr),
        .sdram_din(sdram_din), .sdram_ack(sdram_ack), .sdram_dout(sdram_dout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic we, input logic [24:0] addr, input logic [7:0] din);
        sb_t e;
        e.we = we; e.addr = addr; e.din = din;
        sb.push_back(e);
    endtask

    // One clock step; also scoreboards each new SDRAM request and, when
    // auto_ack is set, plays the SDRAM controller.
    task automatic tick();
        sb_t e;
        @(posedge clk); #1;
        ack_auto = 1'b0;
        if (sdram_req && !prev_req) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected_req actual=addr %0h we %0b required=no request", sdram_addr, sdram_we);
            end else begin
                e = sb.pop_front();
                check("sb_we", {31'd0, sdram_we}, {31'd0, e.we});
                check("sb_addr", {7'd0, sdram_addr}, {7'd0, e.addr});
                if (e.we) check("sb_din", {24'd0, sdram_din}, {24'd0, e.din});
            end
            req_age = 0;
        end else if (sdram_req) begin
            req_age++;
        end
        if (auto_ack && sdram_req && req_age == ack_delay) begin
            ack_auto = 1'b1;
            if (sdram_we) mem[sdram_addr] = sdram_din;
            else dout_auto = mem.exists(sdram_addr) ? mem[sdram_addr] : 8'h00;
        end
        prev_req = sdram_req;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!sdram_req && n < 20) begin
            tick();
            n++;
        end
        check(name, {31'd0, sdram_req}, 32'd1);
    endtask

    task automatic do_ack(input logic [7:0] d);
        ack_man = 1'b1; dout_man = d;
        tick();
        ack_man = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; ram_addr = '0; ram_din = 0; ram_we = 0; ram_rd = 0; flush = 0;
        ack_man = 0; dout_man = 0; ack_auto = 0; dout_auto = 0; auto_ack = 0;
        ack_delay = 2; prev_req = 0; req_age = 0;
        mem[25'h4000] = 8'h3C; mem[25'h0123] = 8'h9E; mem[25'h0] = 8'h01;

        vecs[0]  = '{OP_RD, 25'h4000,    8'h00, 1'b1, 8'h3C};
        vecs[1]  = '{OP_RD, 25'h4000,    8'h00, 1'b0, 8'h3C};
        vecs[2]  = '{OP_WR, 25'h4000,    8'h77, 1'b0, 8'h00};
        vecs[3]  = '{OP_RD, 25'h4000,    8'h00, 1'b0, 8'h77};
        vecs[4]  = '{OP_RD, 25'h0123,    8'h00, 1'b1, 8'h9E};
        vecs[5]  = '{OP_RD, 25'h4000,    8'h00, 1'b1, 8'h77};
        vecs[6]  = '{OP_FL, 25'h4000,    8'h00, 1'b0, 8'hFF};
        vecs[7]  = '{OP_RD, 25'h4000,    8'h00, 1'b1, 8'h77};
        vecs[8]  = '{OP_WR, 25'h1FFFFFF, 8'h12, 1'b0, 8'h00};
        vecs[9]  = '{OP_RD, 25'h1FFFFFF, 8'h00, 1'b1, 8'h12};
        vecs[10] = '{OP_RD, 25'h0,       8'h00, 1'b1, 8'h01};

        repeat (3) tick();
        reset_n = 1;
        #1;
        check("rst_ready", {31'd0, ram_ready}, 32'd1);
        check("rst_req", {31'd0, sdram_req}, 32'd0);
        check("rst_dout", {24'd0, ram_dout}, {24'd0, IDLE_V});
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_addr", {7'd0, sdram_addr}, 32'd0);

        // Write latency with the ack three cycles after the request.
        tick();
        ram_we = 1; ram_addr = 25'h10; ram_din = 8'hA5; push(1'b1, 25'h10, 8'hA5);
        tick();
        ram_we = 0;
        check("wr_ready_c1", {31'd0, ram_ready}, 32'd0);
        check("wr_req_c1", {31'd0, sdram_req}, 32'd0);
        tick();
        check("wr_req_c2", {31'd0, sdram_req}, 32'd1);
        tick(); tick(); tick();
        check("wr_ready_c5", {31'd0, ram_ready}, 32'd0);
        do_ack(8'h00);
        check("wr_ready_c6", {31'd0, ram_ready}, 32'd1);
        check("wr_req_c6", {31'd0, sdram_req}, 32'd0);

        auto_ack = 1;
        for (int i = 0; i < 11; i++) begin
            tick();
            case (vecs[i].op)
                OP_RD: begin
                    ram_addr = vecs[i].addr; ram_rd = 1;
                    #1;
                    check("tbl_rd_wait", {31'd0, cpu_wait}, {31'd0, vecs[i].exp_miss});
                    if (vecs[i].exp_miss) push(1'b0, vecs[i].addr, 8'h00);
                    for (int n = 0; n < 50 && cpu_wait; n++) tick();
                    check("tbl_rd_done", {31'd0, cpu_wait}, 32'd0);
                    check("tbl_rd_dout", {24'd0, ram_dout}, {24'd0, vecs[i].exp_dout});
                    ram_rd = 0;
                end
                OP_WR: begin
                    ram_addr = vecs[i].addr; ram_din = vecs[i].data; ram_we = 1;
                    push(1'b1, vecs[i].addr, vecs[i].data);
                    tick();
                    ram_we = 0;
                    for (int n = 0; n < 50 && !ram_ready; n++) tick();
                    check("tbl_wr_ready", {31'd0, ram_ready}, 32'd1);
                end
                default: begin
                    flush = 1;
                    tick();
                    flush = 0;
                    check("tbl_fl_dout", {24'd0, ram_dout}, {24'd0, vecs[i].exp_dout});
                end
            endcase
        end
        auto_ack = 0;

        // Flush during RD_BUSY discards the fill; the next read re-requests.
        tick();
        ram_addr = 25'h8000; ram_rd = 1; push(1'b0, 25'h8000, 8'h00);
        wait_req("fl_req1");
        check("fl_wait_busy", {31'd0, cpu_wait}, 32'd1);
        flush = 1;
        tick();
        flush = 0;
        check("fl_dout", {24'd0, ram_dout}, {24'd0, IDLE_V});
        tick();
        do_ack(8'h5E);
        check("fl_req_drop", {31'd0, sdram_req}, 32'd0);
        check("fl_wait_after", {31'd0, cpu_wait}, 32'd1);
        push(1'b0, 25'h8000, 8'h00);
        wait_req("fl_req2");
        do_ack(8'h5E);
        check("fl_done", {31'd0, cpu_wait}, 32'd0);
        check("fl_dout2", {24'd0, ram_dout}, 32'h5E);
        ram_rd = 0;

        // Flush in the same cycle as the fill ack: cache stays invalid.
        tick();
        ram_addr = 25'h9000; ram_rd = 1; push(1'b0, 25'h9000, 8'h00);
        wait_req("fa_req");
        tick();
        flush = 1;
        do_ack(8'h44);
        flush = 0; ram_rd = 0;
        check("fa_dout", {24'd0, ram_dout}, {24'd0, IDLE_V});
        ram_rd = 1;
        #1;
        check("fa_miss", {31'd0, cpu_wait}, 32'd1);
        ram_rd = 0;

        // Address change and a buffered write while a read is in flight.
        tick();
        ram_addr = 25'hA000; ram_rd = 1; push(1'b0, 25'hA000, 8'h00);
        wait_req("ac_req");
        ram_addr = 25'hB000; ram_we = 1; ram_din = 8'h66; push(1'b1, 25'hB000, 8'h66);
        tick();
        ram_we = 0;
        check("ac_ready", {31'd0, ram_ready}, 32'd0);
        check("ac_wait", {31'd0, cpu_wait}, 32'd1);
        tick();
        do_ack(8'h7A);
        check("ac_req_drop", {31'd0, sdram_req}, 32'd0);
        ram_addr = 25'hA000;
        #1;
        check("ac_tag_hit", {31'd0, cpu_wait}, 32'd0);
        check("ac_tag_dout", {24'd0, ram_dout}, 32'h7A);
        ram_addr = 25'hB000;
        wait_req("ac_wr_req");
        tick();
        do_ack(8'h00);
        push(1'b0, 25'hB000, 8'h00);
        wait_req("ac_rd_req");
        do_ack(8'h66);
        check("ac_done", {31'd0, cpu_wait}, 32'd0);
        check("ac_dout", {24'd0, ram_dout}, 32'h66);
        ram_rd = 0;

        // Back-to-back writes while the first is pending: second is dropped.
        tick();
        ram_we = 1; ram_addr = 25'h20; ram_din = 8'h11; push(1'b1, 25'h20, 8'h11);
        tick();
        ram_addr = 25'h21; ram_din = 8'h22;
        tick();
        ram_we = 0;
        check("ov_flag", {31'd0, overflow}, 32'd1);
        check("ov_req", {31'd0, sdram_req}, 32'd1);
        repeat (3) tick();
        check("ov_ready_low", {31'd0, ram_ready}, 32'd0);
        do_ack(8'h00);
        tick(); tick(); tick();
        check("ov_no_second", {31'd0, sdram_req}, 32'd0);
        check("ov_sticky", {31'd0, overflow}, 32'd1);
        check("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
